// File: rtl/csr_trap_sequencer_pkg.sv
// Shared constants for the machine-mode trap/mret CSR sequencer:
// CSR addresses, mstatus bit positions, FSM state encodings and cause codes.
package csr_trap_sequencer_pkg;

    // XLEN width codes: data width W = 1 << (code + 4)
    localparam logic [1:0] XLEN_32B = 2'd1;
    localparam logic [1:0] XLEN_64B = 2'd2;

    // Machine-mode CSR addresses
    localparam logic [11:0] REG_MSTATUS_ADDR = 12'h300;
    localparam logic [11:0] REG_MTVEC_ADDR   = 12'h305;
    localparam logic [11:0] REG_MEPC_ADDR    = 12'h341;
    localparam logic [11:0] REG_MCAUSE_ADDR  = 12'h342;
    localparam logic [11:0] REG_MTVAL_ADDR   = 12'h343;

    // mstatus field positions
    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MSTATUS_MPP_LO   = 11;

    // mtvec mode field value selecting vectored interrupts
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    // Trap FSM state encodings
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_T_MEPC   = 3'd1;
    localparam logic [2:0] ST_T_MCAUSE = 3'd2;
    localparam logic [2:0] ST_T_MTVAL  = 3'd3;
    localparam logic [2:0] ST_T_STATUS = 3'd4;
    localparam logic [2:0] ST_T_REDIR  = 3'd5;
    localparam logic [2:0] ST_R_STATUS = 3'd6;
    localparam logic [2:0] ST_R_REDIR  = 3'd7;

    // Synchronous exception cause codes
    localparam logic [4:0] E_INST_ADDR_MISALIGNED  = 5'd0;
    localparam logic [4:0] E_INST_ACCESS_FAULT     = 5'd1;
    localparam logic [4:0] E_ILLEGAL_INST          = 5'd2;
    localparam logic [4:0] E_BREAKPOINT            = 5'd3;
    localparam logic [4:0] E_LOAD_ADDR_MISALIGNED  = 5'd4;
    localparam logic [4:0] E_LOAD_ACCESS_FAULT     = 5'd5;
    localparam logic [4:0] E_STORE_ADDR_MISALIGNED = 5'd6;
    localparam logic [4:0] E_STORE_ACCESS_FAULT    = 5'd7;
    localparam logic [4:0] E_ECALL_U               = 5'd8;
    localparam logic [4:0] E_ECALL_S               = 5'd9;
    localparam logic [4:0] E_ECALL_M               = 5'd11;
    localparam logic [4:0] E_INST_PAGE_FAULT       = 5'd12;
    localparam logic [4:0] E_LOAD_PAGE_FAULT       = 5'd13;
    localparam logic [4:0] E_STORE_PAGE_FAULT      = 5'd15;

    // Latched trap identity
    typedef struct packed {
        logic       is_int;
        logic [4:0] cause;
    } trap_cause_t;

    // Data width in bits for an XLEN width code
    function automatic int unsigned xlen_width(input logic [1:0] code);
        return 32'd1 << (32'(code) + 32'd4);
    endfunction

endpackage

// File: rtl/csr_trap_target_calc.sv
// Trap vector target: mtvec base, plus cause*4 for vectored interrupts.
// Modes 10/11 fall back to direct; vectoring can be disabled outright.
module csr_trap_target_calc
    import csr_trap_sequencer_pkg::*;
#(
    parameter int unsigned W           = 64,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic [W-1:0] mtvec,
    input  logic         is_int,
    input  logic [4:0]   cause,
    output logic [W-1:0] target_pc
);

    logic [W-1:0] base;
    logic [W-1:0] offset;

    // Select direct base or base + cause*4 (wraps modulo 2^W)
    always_comb begin
        base        = {mtvec[W-1:2], 2'b00};
        offset      = '0;
        offset[6:2] = cause;
        if (VECTORED_EN && is_int && (mtvec[1:0] == MTVEC_MODE_VECTORED)) begin
            target_pc = base + offset;
        end else begin
            target_pc = base;
        end
    end

endmodule

// File: rtl/csr_trap_sequencer.sv
// Hardware-side CSR writer for machine-mode trap entry and mret return.
// Drives the CSR file's second port: saves mepc/mcause/(mtval), updates
// mstatus, then redirects fetch to mtvec or back to mepc.
// Optional: define CSR_TRAP_MTVAL_EN to include the mtval write state.
module csr_trap_sequencer
    import csr_trap_sequencer_pkg::*;
#(
    parameter logic [1:0]   XLEN              = XLEN_64B,
    parameter bit           MTVEC_VECTORED_EN = 1'b1,
    localparam int unsigned W                 = xlen_width(XLEN)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_trap_valid,
    input  logic         i_trap_is_int,
    input  logic [4:0]   i_trap_cause,
    input  logic [W-1:0] i_trap_pc,
    input  logic [W-1:0] i_trap_tval,
    input  logic         i_mret_valid,
    output logic         o_busy,
    output logic         o_flush,
    output logic         o_redirect_valid,
    output logic [W-1:0] o_redirect_pc,
    output logic [11:0]  o_csr_raddr,
    input  logic [W-1:0] i_csr_rdata,
    output logic         o_csr_we,
    output logic [11:0]  o_csr_waddr,
    output logic [W-1:0] o_csr_wdata
);

    logic [2:0]   state;
    logic [2:0]   state_nx;
    trap_cause_t  trap_q;
    logic [W-1:2] pc_q;
    logic         accept_trap;
    logic         accept_mret;
    logic [W-1:0] status_trap;
    logic [W-1:0] status_mret;
    logic [W-1:0] trap_target;

`ifdef CSR_TRAP_MTVAL_EN
    logic [W-1:0] tval_q;
`else
    logic         unused_tval;
    assign unused_tval = ^i_trap_tval;
`endif

    assign accept_trap = (state == ST_IDLE) && i_trap_valid;
    assign accept_mret = (state == ST_IDLE) && !i_trap_valid && i_mret_valid;

    csr_trap_target_calc #(
        .W           (W),
        .VECTORED_EN (MTVEC_VECTORED_EN)
    ) u_target_calc (
        .mtvec     (i_csr_rdata),
        .is_int    (trap_q.is_int),
        .cause     (trap_q.cause),
        .target_pc (trap_target)
    );

    // State register and trap context capture at acceptance
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            trap_q <= '0;
            pc_q   <= '0;
`ifdef CSR_TRAP_MTVAL_EN
            tval_q <= '0;
`endif
        end else begin
            state <= state_nx;
            if (accept_trap) begin
                trap_q.is_int <= i_trap_is_int;
                trap_q.cause  <= i_trap_cause;
                pc_q          <= i_trap_pc[W-1:2];
`ifdef CSR_TRAP_MTVAL_EN
                tval_q        <= i_trap_tval;
`endif
            end
        end
    end

    // Sequencing: one CSR write or one redirect per state
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept_trap) begin
                    state_nx = ST_T_MEPC;
                end else if (accept_mret) begin
                    state_nx = ST_R_STATUS;
                end
            end
            ST_T_MEPC:   state_nx = ST_T_MCAUSE;
`ifdef CSR_TRAP_MTVAL_EN
            ST_T_MCAUSE: state_nx = ST_T_MTVAL;
            ST_T_MTVAL:  state_nx = ST_T_STATUS;
`else
            ST_T_MCAUSE: state_nx = ST_T_STATUS;
`endif
            ST_T_STATUS: state_nx = ST_T_REDIR;
            ST_T_REDIR:  state_nx = ST_IDLE;
            ST_R_STATUS: state_nx = ST_R_REDIR;
            ST_R_REDIR:  state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // mstatus images for trap entry and mret, other bits pass through
    always_comb begin
        status_trap                     = i_csr_rdata;
        status_trap[MSTATUS_MPIE_BIT]   = i_csr_rdata[MSTATUS_MIE_BIT];
        status_trap[MSTATUS_MIE_BIT]    = 1'b0;
        status_trap[MSTATUS_MPP_LO +: 2] = 2'b11;

        status_mret                     = i_csr_rdata;
        status_mret[MSTATUS_MIE_BIT]    = i_csr_rdata[MSTATUS_MPIE_BIT];
        status_mret[MSTATUS_MPIE_BIT]   = 1'b1;
        status_mret[MSTATUS_MPP_LO +: 2] = 2'b11;
    end

    // Per-state CSR port and redirect outputs; idle drives all zeros
    always_comb begin
        o_csr_raddr      = '0;
        o_csr_we         = 1'b0;
        o_csr_waddr      = '0;
        o_csr_wdata      = '0;
        o_redirect_valid = 1'b0;
        o_redirect_pc    = '0;
        case (state)
            ST_T_MEPC: begin
                o_csr_we    = 1'b1;
                o_csr_waddr = REG_MEPC_ADDR;
                o_csr_wdata = {pc_q, 2'b00};
            end
            ST_T_MCAUSE: begin
                o_csr_we    = 1'b1;
                o_csr_waddr = REG_MCAUSE_ADDR;
                o_csr_wdata = {trap_q.is_int, {(W-6){1'b0}}, trap_q.cause};
            end
`ifdef CSR_TRAP_MTVAL_EN
            ST_T_MTVAL: begin
                o_csr_we    = 1'b1;
                o_csr_waddr = REG_MTVAL_ADDR;
                o_csr_wdata = tval_q;
            end
`endif
            ST_T_STATUS: begin
                o_csr_raddr = REG_MSTATUS_ADDR;
                o_csr_we    = 1'b1;
                o_csr_waddr = REG_MSTATUS_ADDR;
                o_csr_wdata = status_trap;
            end
            ST_T_REDIR: begin
                o_csr_raddr      = REG_MTVEC_ADDR;
                o_redirect_valid = 1'b1;
                o_redirect_pc    = trap_target;
            end
            ST_R_STATUS: begin
                o_csr_raddr = REG_MSTATUS_ADDR;
                o_csr_we    = 1'b1;
                o_csr_waddr = REG_MSTATUS_ADDR;
                o_csr_wdata = status_mret;
            end
            ST_R_REDIR: begin
                o_csr_raddr      = REG_MEPC_ADDR;
                o_redirect_valid = 1'b1;
                o_redirect_pc    = {i_csr_rdata[W-1:2], 2'b00};
            end
            default: begin
            end
        endcase
    end

    assign o_busy = (state != ST_IDLE);
    // Flush is decoded from live inputs, so it is masked while reset is held
    assign o_flush = i_rst_n && (accept_trap || accept_mret);

endmodule
